div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/div_unit_if.sv | 43 ++++
 rtl/div_step.sv | 34 +++
 rtl/div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the integer divide unit.
//   XLEN        : datapath width (only 32 is supported)
//   div_op_e    : RV32M divide/remainder opcode encoding
//   div_state_e : divide-unit FSM states
//   abs_val()   : two's-complement magnitude helper
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Magnitude of a signed value. 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// ----------------------------------------------------------------------------
// div_unit_if
// Issue and write-back signals of the divide unit.
//   i_valid/o_ready        : issue handshake
//   i_op, i_rs1_val,
//   i_rs2_val, i_rd        : operation, operands, destination register
//   i_flush                : synchronous abort
//   o_wb_en/o_wb_rd/o_wb_val : register-file write port
//   o_busy                 : unit not idle
//   o_dbg_state            : current FSM state, for observation only
//
// Handshake: an operation is accepted on a rising edge where i_valid and
// o_ready are both high and i_flush is low. The requester keeps i_op and the
// operands stable while i_valid is high. o_ready is high only in IDLE, so
// there is never more than one operation in flight.
// ----------------------------------------------------------------------------
interface div_unit_if;
    import riscv_pkg::*;

    logic             i_valid;
    logic             o_ready;
    div_op_e          i_op;
    logic [XLEN-1:0]  i_rs1_val;
    logic [XLEN-1:0]  i_rs2_val;
    logic [4:0]       i_rd;
    logic             i_flush;
    logic             o_wb_en;
    logic [4:0]       o_wb_rd;
    logic [XLEN-1:0]  o_wb_val;
    logic             o_busy;
    div_state_e       o_dbg_state;

    modport master (
        output i_valid, i_op, i_rs1_val, i_rs2_val, i_rd, i_flush,
        input  o_ready, o_wb_en, o_wb_rd, o_wb_val, o_busy, o_dbg_state
    );

    modport slave (
        input  i_valid, i_op, i_rs1_val, i_rs2_val, i_rd, i_flush,
        output o_ready, o_wb_en, o_wb_rd, o_wb_val, o_busy, o_dbg_state
    );

endinterface

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One radix-2 restoring division iteration, purely combinational.
//   rem_in, quo_in : current partial remainder and quotient/dividend shifter
//   divisor        : unsigned divisor
//   rem_out        : next partial remainder
//   quo_out        : next quotient shifter (new quotient bit in bit 0)
// ----------------------------------------------------------------------------
module div_step
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          take;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // When the shifted remainder has its top bit set it is at least 2^32
        // and therefore larger than any divisor, even though the 33-bit
        // difference sign bit cannot show it.
        take    = shifted[XLEN] | ~diff[XLEN];
        rem_out = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], take};
    end

endmodule

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Multi-cycle RV32M integer divider (DIV, DIVU, REM, REMU).
//   i_clk : clock, rising edge
//   i_rst : asynchronous, active-low reset
//   bus   : div_unit_if slave (issue handshake, flush, write-back, status)
//
// Flow: IDLE -accept-> PREP -> CALC (32 restoring steps) -> FIX -> DONE.
// Divide-by-zero and signed overflow are resolved in PREP and go straight
// to DONE. The write-back pulse is asserted during the DONE cycle.
// ----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic      i_clk,
    input  logic      i_rst,
    div_unit_if.slave bus
);
    import riscv_pkg::*;

    localparam logic [5:0] ITERATIONS = 6'd32;

    div_state_e      state_q, state_d;

    div_op_e         op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [5:0]      cnt_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic            wb_en_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_val_q;

    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;

    logic            accept;
    logic            is_signed;
    logic            is_rem;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_val;
    logic            wb_load;
    logic [XLEN-1:0] wb_val_d;

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // Operation decode, special cases and sign fix-up, all from latched state.
    always_comb begin
        accept      = (state_q == IDLE) && bus.i_valid && !bus.i_flush;
        is_signed   = (op_q == DIV) || (op_q == REM);
        is_rem      = op_q[1];
        div_zero    = (b_q == '0);
        overflow    = is_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}})
                                && (b_q == '1);
        special     = div_zero || overflow;
        if (div_zero) begin
            special_val = is_rem ? a_q : '1;
        end else begin
            // Overflow: quotient is the dividend itself, remainder is zero.
            special_val = is_rem ? '0 : a_q;
        end
        q_fix   = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix   = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        fix_val = is_rem ? r_fix : q_fix;
    end

    // Next-state and write-back load decision.
    always_comb begin
        state_d  = state_q;
        wb_load  = 1'b0;
        wb_val_d = '0;
        case (state_q)
            IDLE: if (accept) state_d = PREP;
            PREP: begin
                if (special) begin
                    state_d  = DONE;
                    wb_load  = 1'b1;
                    wb_val_d = special_val;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: if (cnt_q == 6'd1) state_d = FIX;
            FIX: begin
                state_d  = DONE;
                wb_load  = 1'b1;
                wb_val_d = fix_val;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including a result about to be written.
        if (bus.i_flush) begin
            state_d = IDLE;
            wb_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch and iterative datapath.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            op_q    <= DIV;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.i_op;
                a_q  <= bus.i_rs1_val;
                b_q  <= bus.i_rs2_val;
                rd_q <= bus.i_rd;
            end
            if (state_q == PREP) begin
                rem_q   <= '0;
                quo_q   <= is_signed ? abs_val(a_q) : a_q;
                dvs_q   <= is_signed ? abs_val(b_q) : b_q;
                cnt_q   <= ITERATIONS;
                q_neg_q <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                r_neg_q <= is_signed && a_q[XLEN-1];
            end else if (state_q == CALC) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - 6'd1;
            end
        end
    end

    // Registered write-back port; value and index only change on a pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wb_en_q  <= 1'b0;
            wb_rd_q  <= '0;
            wb_val_q <= '0;
        end else begin
            wb_en_q <= wb_load && (rd_q != 5'd0);
            if (wb_load && (rd_q != 5'd0)) begin
                wb_rd_q  <= rd_q;
                wb_val_q <= wb_val_d;
            end
        end
    end

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_wb_en     = wb_en_q;
    assign bus.o_wb_rd     = wb_rd_q;
    assign bus.o_wb_val    = wb_val_q;
    assign bus.o_dbg_state = state_q;

endmodule
